// File: rtl/rv2t_decode_stage.sv
// rv2t_decode_stage: elastic RV32 decode stage.
// Decodes an instruction word on the fly and stores the result in a
// 2-entry skid buffer. Fetch and execute are decoupled, and in_ready is a
// plain register output with no combinational path from out_ready.
// A saturating counter tracks accepted instructions.
module rv2t_decode_stage #(
    parameter int XLEN           = 32,
    parameter int PC_BITWIDTH    = 32,
    parameter int ENABLE_MUL_DIV = 1,
    parameter int ENABLE_CSR     = 1,
    parameter int CNT_BITS       = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sync_reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        IR_in,
    input  logic [PC_BITWIDTH-1:0] PC_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-3:0]        IR_out,
    output logic [PC_BITWIDTH-1:0] PC_out,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    output logic [4:0]             rd,
    output logic [18:0]            ctl,
    output logic                   exception_illegal_instruction,
    output logic [CNT_BITS-1:0]    decode_count
);

    localparam bit MULDIV_EN = (ENABLE_MUL_DIV != 0);
    localparam bit CSR_EN    = (ENABLE_CSR != 0);

    // Opcode field IR[6:2]
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;

    // Strobe bit positions within ctl
    localparam int C_X_RS1   = 0;
    localparam int C_Y_RS2   = 1;
    localparam int C_Y_IMM   = 2;
    localparam int C_RD      = 3;
    localparam int C_ALU     = 4;
    localparam int C_MULDIV  = 5;
    localparam int C_LUI     = 6;
    localparam int C_AUIPC   = 7;
    localparam int C_JAL     = 8;
    localparam int C_JALR    = 9;
    localparam int C_BRANCH  = 10;
    localparam int C_LOAD    = 11;
    localparam int C_STORE   = 12;
    localparam int C_SYSTEM  = 13;
    localparam int C_CSR     = 14;
    localparam int C_CSR_WR  = 15;
    localparam int C_MISCMEM = 16;
    localparam int C_MRET    = 17;
    localparam int C_WFI     = 18;

    // One buffered decode result; IR is kept as IR[31:2]
    typedef struct packed {
        logic [XLEN-3:0]        ir;
        logic [PC_BITWIDTH-1:0] pc;
        logic [18:0]            ctl;
        logic                   ill;
    } entry_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    entry_t                head_q, head_d;
    entry_t                tail_q, tail_d;
    logic                  in_ready_q, in_ready_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;

    logic [18:0]           dec_ctl;
    logic                  dec_ill;
    entry_t                dec_entry;
    logic                  acc;
    logic                  pop;
    logic                  clear;

    logic [4:0]            opcode;
    logic [2:0]            funct3;
    logic [4:0]            f_rs1;
    logic [4:0]            f_rs2;
    logic                  csr_op;

    assign opcode = IR_in[6:2];
    assign funct3 = IR_in[14:12];
    assign f_rs1  = IR_in[19:15];
    assign f_rs2  = IR_in[24:20];
    assign csr_op = |funct3;

    // Combinational decode of the incoming instruction word
    always_comb begin
        dec_ctl = '0;
        dec_ill = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                dec_ctl[C_X_RS1] = 1'b1;
                dec_ctl[C_Y_IMM] = 1'b1;
                dec_ctl[C_RD]    = 1'b1;
                dec_ctl[C_ALU]   = 1'b1;
            end
            OPC_OP: begin
                dec_ctl[C_X_RS1]  = 1'b1;
                dec_ctl[C_Y_RS2]  = 1'b1;
                dec_ctl[C_RD]     = 1'b1;
                dec_ctl[C_ALU]    = ~IR_in[25];
                dec_ctl[C_MULDIV] = IR_in[25];
                if (!MULDIV_EN && IR_in[25]) dec_ill = 1'b1;
            end
            OPC_LUI: begin
                dec_ctl[C_LUI] = 1'b1;
                dec_ctl[C_RD]  = 1'b1;
            end
            OPC_AUIPC: begin
                dec_ctl[C_AUIPC] = 1'b1;
                dec_ctl[C_RD]    = 1'b1;
            end
            OPC_JAL: begin
                dec_ctl[C_JAL] = 1'b1;
                dec_ctl[C_RD]  = 1'b1;
            end
            OPC_JALR: begin
                dec_ctl[C_JALR]  = 1'b1;
                dec_ctl[C_RD]    = 1'b1;
                dec_ctl[C_X_RS1] = 1'b1;
            end
            OPC_BRANCH: begin
                dec_ctl[C_BRANCH] = 1'b1;
                dec_ctl[C_X_RS1]  = 1'b1;
                dec_ctl[C_Y_RS2]  = 1'b1;
            end
            OPC_LOAD: begin
                dec_ctl[C_LOAD]  = 1'b1;
                dec_ctl[C_X_RS1] = 1'b1;
            end
            OPC_STORE: begin
                dec_ctl[C_STORE]  = 1'b1;
                dec_ctl[C_X_RS1]  = 1'b1;
                dec_ctl[C_Y_RS2]  = 1'b1;
            end
            OPC_SYSTEM: begin
                dec_ctl[C_SYSTEM] = 1'b1;
                dec_ctl[C_X_RS1]  = 1'b1;
                if (!csr_op && f_rs2 == 5'b00010) begin
                    dec_ctl[C_MRET] = 1'b1;
                end else if (!csr_op && f_rs2 == 5'b00101) begin
                    dec_ctl[C_WFI] = 1'b1;
                end else begin
                    dec_ctl[C_CSR]    = csr_op;
                    dec_ctl[C_RD]     = csr_op;
                    dec_ctl[C_CSR_WR] = csr_op & (|f_rs1);
                end
                if (!CSR_EN && csr_op) dec_ill = 1'b1;
            end
            OPC_MISC_MEM: begin
                // FENCE.I raises the strobe; plain FENCE is a legal no-op
                if (funct3 == 3'b001)      dec_ctl[C_MISCMEM] = 1'b1;
                else if (funct3 != 3'b000) dec_ill = 1'b1;
            end
            default: dec_ill = 1'b1;
        endcase
        if (IR_in == '0 || IR_in == '1 || IR_in[1:0] != 2'b11) dec_ill = 1'b1;
        // Illegal entries never carry strobes downstream
        if (dec_ill) dec_ctl = '0;
    end

    assign dec_entry = '{ir: IR_in[XLEN-1:2], pc: PC_in, ctl: dec_ctl, ill: dec_ill};

    assign clear     = flush | sync_reset;
    assign out_valid = (state_q != S_EMPTY);
    assign acc       = in_valid & in_ready_q & ~clear;
    assign pop       = out_valid & out_ready;

    // Skid buffer next-state: head is the oldest entry, tail the second
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (clear) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (acc) begin
                        head_d  = dec_entry;
                        state_d = S_ONE;
                    end
                end
                S_ONE: begin
                    if (acc && pop) begin
                        head_d = dec_entry;
                    end else if (acc) begin
                        tail_d  = dec_entry;
                        state_d = S_FULL;
                    end else if (pop) begin
                        state_d = S_EMPTY;
                    end
                end
                S_FULL: begin
                    // in_ready is low here, so no accept can coincide
                    if (pop) begin
                        head_d  = tail_q;
                        state_d = S_ONE;
                    end
                end
                default: state_d = S_EMPTY;
            endcase
        end
        // Registered ready: derived from the state we are about to enter
        in_ready_d = (state_d != S_FULL);
    end

    // Saturating accept counter; sync_reset clears, flush does not
    always_comb begin
        cnt_d = cnt_q;
        if (sync_reset)              cnt_d = '0;
        else if (acc && cnt_q != '1) cnt_d = cnt_q + CNT_BITS'(1);
    end

    // State, buffer, ready and counter registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready                      = in_ready_q;
    assign IR_out                        = head_q.ir;
    assign PC_out                        = head_q.pc;
    assign rs1                           = head_q.ir[17:13];
    assign rs2                           = head_q.ir[22:18];
    assign rd                            = head_q.ir[9:5];
    assign ctl                           = head_q.ctl;
    assign exception_illegal_instruction = head_q.ill;
    assign decode_count                  = cnt_q;

endmodule

// File: tb/tb_rv2t_decode_stage.sv
// Testbench for rv2t_decode_stage. Two instances share all inputs: dut_a
// uses default parameters, dut_b disables M and CSR and has a 3-bit counter.
// Expected results are queued per instance at accept time and compared
// against the head entry while it is valid.
module tb_rv2t_decode_stage;

    logic        clk;
    logic        reset_n;
    logic        sync_reset;
    logic        flush;
    logic        in_valid;
    logic [31:0] IR_in;
    logic [31:0] PC_in;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, ill_a;
    logic [29:0] IR_out_a;
    logic [31:0] PC_out_a;
    logic [4:0]  rs1_a, rs2_a, rd_a;
    logic [18:0] ctl_a;
    logic [15:0] cnt_out_a;

    logic        in_ready_b, out_valid_b, ill_b;
    logic [29:0] IR_out_b;
    logic [31:0] PC_out_b;
    logic [4:0]  rs1_b, rs2_b, rd_b;
    logic [18:0] ctl_b;
    logic [2:0]  cnt_out_b;

    rv2t_decode_stage dut_a (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .IR_in(IR_in), .PC_in(PC_in),
        .out_valid(out_valid_a), .out_ready(out_ready), .IR_out(IR_out_a),
        .PC_out(PC_out_a), .rs1(rs1_a), .rs2(rs2_a), .rd(rd_a), .ctl(ctl_a),
        .exception_illegal_instruction(ill_a), .decode_count(cnt_out_a)
    );

    rv2t_decode_stage #(
        .ENABLE_MUL_DIV(0), .ENABLE_CSR(0), .CNT_BITS(3)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .sync_reset(sync_reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .IR_in(IR_in), .PC_in(PC_in),
        .out_valid(out_valid_b), .out_ready(out_ready), .IR_out(IR_out_b),
        .PC_out(PC_out_b), .rs1(rs1_b), .rs2(rs2_b), .rd(rd_b), .ctl(ctl_b),
        .exception_illegal_instruction(ill_b), .decode_count(cnt_out_b)
    );

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [18:0] ctl;
        logic        ill;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    int unsigned cnt_a;
    int unsigned cnt_b;
    int          n_tests;
    int          n_fail;

    // expectations for the word currently on IR_in
    logic [18:0] cur_ctl_a, cur_ctl_b;
    logic        cur_ill_a, cur_ill_b;
    logic [31:0] pc_next;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard/monitor at negedge: checks current outputs, then advances
    // the model by what the coming posedge will do.
    always @(negedge clk) begin
        if (!reset_n) begin
            check("rst_out_valid_a", 32'(out_valid_a), 32'd0);
            check("rst_in_ready_a",  32'(in_ready_a),  32'd1);
            check("rst_ir_a",        32'(IR_out_a),    32'd0);
            check("rst_pc_a",        PC_out_a,         32'd0);
            check("rst_fields_a",    32'({rs1_a, rs2_a, rd_a}), 32'd0);
            check("rst_ctl_a",       32'(ctl_a),       32'd0);
            check("rst_ill_a",       32'(ill_a),       32'd0);
            check("rst_cnt_a",       32'(cnt_out_a),   32'd0);
            check("rst_out_valid_b", 32'(out_valid_b), 32'd0);
            check("rst_in_ready_b",  32'(in_ready_b),  32'd1);
            check("rst_cnt_b",       32'(cnt_out_b),   32'd0);
            qa.delete();
            qb.delete();
            cnt_a = 0;
            cnt_b = 0;
        end else begin
            check("out_valid_a", 32'(out_valid_a), 32'(qa.size() != 0));
            check("in_ready_a",  32'(in_ready_a),  32'(qa.size() < 2));
            check("out_valid_b", 32'(out_valid_b), 32'(qb.size() != 0));
            check("in_ready_b",  32'(in_ready_b),  32'(qb.size() < 2));
            check("count_a",     32'(cnt_out_a),   cnt_a);
            check("count_b",     32'(cnt_out_b),   cnt_b);
            if (out_valid_a && qa.size() != 0) begin
                check("ir_a",  32'(IR_out_a), 32'(qa[0].ir[31:2]));
                check("pc_a",  PC_out_a,      qa[0].pc);
                check("rs1_a", 32'(rs1_a),    32'(qa[0].ir[19:15]));
                check("rs2_a", 32'(rs2_a),    32'(qa[0].ir[24:20]));
                check("rd_a",  32'(rd_a),     32'(qa[0].ir[11:7]));
                check("ctl_a", 32'(ctl_a),    32'(qa[0].ctl));
                check("ill_a", 32'(ill_a),    32'(qa[0].ill));
            end
            if (out_valid_b && qb.size() != 0) begin
                check("ir_b",  32'(IR_out_b), 32'(qb[0].ir[31:2]));
                check("pc_b",  PC_out_b,      qb[0].pc);
                check("ctl_b", 32'(ctl_b),    32'(qb[0].ctl));
                check("ill_b", 32'(ill_b),    32'(qb[0].ill));
            end
            if (flush || sync_reset) begin
                qa.delete();
                qb.delete();
                if (sync_reset) begin
                    cnt_a = 0;
                    cnt_b = 0;
                end
            end else begin
                logic acc_a, acc_b;
                acc_a = in_valid && (qa.size() < 2);
                acc_b = in_valid && (qb.size() < 2);
                if (out_ready && qa.size() != 0) void'(qa.pop_front());
                if (out_ready && qb.size() != 0) void'(qb.pop_front());
                if (acc_a) begin
                    qa.push_back('{ir: IR_in, pc: PC_in, ctl: cur_ctl_a, ill: cur_ill_a});
                    if (cnt_a != 65535) cnt_a++;
                end
                if (acc_b) begin
                    qb.push_back('{ir: IR_in, pc: PC_in, ctl: cur_ctl_b, ill: cur_ill_b});
                    if (cnt_b != 7) cnt_b++;
                end
            end
        end
    end

    // Offer one instruction and hold it until accepted (bounded wait)
    task automatic send(input logic [31:0] ir, input logic [18:0] ca, input logic ia,
                        input logic [18:0] cb, input logic ib);
        bit ok;
        ok        = 1'b0;
        IR_in     = ir;
        PC_in     = pc_next;
        cur_ctl_a = ca;
        cur_ill_a = ia;
        cur_ctl_b = cb;
        cur_ill_b = ib;
        in_valid  = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready_a) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        pc_next  = pc_next + 32'd4;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain", 32'(qa.size() + qb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned saved_cnt;
        n_tests    = 0;
        n_fail     = 0;
        cnt_a      = 0;
        cnt_b      = 0;
        reset_n    = 1'b1;
        sync_reset = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        IR_in      = '0;
        PC_in      = '0;
        cur_ctl_a  = '0;
        cur_ctl_b  = '0;
        cur_ill_a  = 1'b0;
        cur_ill_b  = 1'b0;
        pc_next    = 32'h0000_1000;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // Streaming at full rate
        out_ready = 1'b1;
        send(32'h00500093, 19'h0001D, 1'b0, 19'h0001D, 1'b0);   // ADDI x1,x0,5
        send(32'h02208033, 19'h0002B, 1'b0, 19'h00000, 1'b1);   // MUL
        send(32'h0000A103, 19'h00801, 1'b0, 19'h00801, 1'b0);   // LW
        drain();
        check("stream_count_a", 32'(cnt_out_a), 32'd3);

        // Backpressure: three offered while out_ready low for 4 cycles
        out_ready = 1'b0;
        fork
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
            begin
                send(32'h002080B3, 19'h0001B, 1'b0, 19'h0001B, 1'b0); // ADD
                send(32'h0040006F, 19'h00108, 1'b0, 19'h00108, 1'b0); // JAL
                send(32'h123450B7, 19'h00048, 1'b0, 19'h00048, 1'b0); // LUI
            end
        join
        drain();

        // Illegal words
        send(32'h00000000, 19'h0, 1'b1, 19'h0, 1'b1);
        send(32'hFFFFFFFF, 19'h0, 1'b1, 19'h0, 1'b1);
        send(32'h00000012, 19'h0, 1'b1, 19'h0, 1'b1);           // IR[1:0]=10
        send(32'h0000007F, 19'h0, 1'b1, 19'h0, 1'b1);           // opcode 11111
        send(32'h0000200F, 19'h0, 1'b1, 19'h0, 1'b1);           // MISC_MEM funct3=010

        // SYSTEM, MISC_MEM and remaining opcodes
        send(32'h30200073, 19'h22001, 1'b0, 19'h22001, 1'b0);   // MRET
        send(32'h300110F3, 19'h0E009, 1'b0, 19'h00000, 1'b1);   // CSRRW x1,mstatus,x2
        send(32'h300020F3, 19'h06009, 1'b0, 19'h00000, 1'b1);   // CSRRS x1,mstatus,x0
        send(32'h10500073, 19'h42001, 1'b0, 19'h42001, 1'b0);   // WFI
        send(32'h00000073, 19'h02001, 1'b0, 19'h02001, 1'b0);   // ECALL
        send(32'h0000100F, 19'h10000, 1'b0, 19'h10000, 1'b0);   // FENCE.I
        send(32'h0000000F, 19'h00000, 1'b0, 19'h00000, 1'b0);   // FENCE
        send(32'h00208463, 19'h00403, 1'b0, 19'h00403, 1'b0);   // BEQ
        send(32'h0020A023, 19'h01003, 1'b0, 19'h01003, 1'b0);   // SW
        send(32'h000080E7, 19'h00209, 1'b0, 19'h00209, 1'b0);   // JALR
        send(32'h00000097, 19'h00088, 1'b0, 19'h00088, 1'b0);   // AUIPC
        drain();
        check("sat_count_b", 32'(cnt_out_b), 32'd7);
        check("count_a_total", 32'(cnt_out_a), 32'd22);

        // Flush while FULL with a same-cycle offer
        out_ready = 1'b0;
        send(32'h00100093, 19'h0001D, 1'b0, 19'h0001D, 1'b0);
        send(32'h00200113, 19'h0001D, 1'b0, 19'h0001D, 1'b0);
        saved_cnt = 32'(cnt_out_a);
        IR_in     = 32'h00300193;
        PC_in     = 32'hDEAD_0000;
        in_valid  = 1'b1;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 32'(out_valid_a), 32'd0);
        check("flush_in_ready",  32'(in_ready_a),  32'd1);
        check("flush_count",     32'(cnt_out_a),   saved_cnt);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Synchronous clear
        send(32'h00500093, 19'h0001D, 1'b0, 19'h0001D, 1'b0);
        sync_reset = 1'b1;
        @(posedge clk);
        #1 sync_reset = 1'b0;
        check("srst_count_a", 32'(cnt_out_a), 32'd0);
        check("srst_count_b", 32'(cnt_out_b), 32'd0);

        // Asynchronous reset pulse with the buffer full
        out_ready = 1'b0;
        send(32'h0000A103, 19'h00801, 1'b0, 19'h00801, 1'b0);
        send(32'h02208033, 19'h0002B, 1'b0, 19'h00000, 1'b1);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        send(32'h00500093, 19'h0001D, 1'b0, 19'h0001D, 1'b0);
        drain();
        check("post_reset_count", 32'(cnt_out_a), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
